// File: rtl/usb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : usb_bit_stuffer
// Description : USB transmit bit stuffer. Sits between the CRC generator and
//               the NRZI encoder. Packet bits pass straight through with zero
//               latency. After every STUFF_LEN consecutive 1s a single 0 is
//               inserted, and the upstream stage is held for that cycle. The
//               block also pulses stuff_done once the last bit of a packet has
//               left, and keeps a saturating count of the 0s it inserted.
//
// Ports       : clk          - clock
//               rst_L        - asynchronous, active-low reset
//               in           - serial data bit from the CRC stage
//               stream_begin - in is the first bit of a packet (IDLE only)
//               stream_done  - in is the last bit of the packet
//               halt_in      - downstream hold; freezes the block
//               out          - serial bit to the NRZI encoder
//               out_valid    - out carries a packet bit this cycle
//               halt_stream  - upstream hold
//               stuff_done   - one-cycle pulse after the final packet bit
//               stuff_count  - number of 0s inserted in current/last packet
//
// Parameters  : STUFF_LEN    - run of 1s that triggers a stuffed 0 (2..7)
//               CNT_W        - width of the saturating stuffed-bit counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module usb_bit_stuffer #(
    parameter int STUFF_LEN = 6,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             in,
    input  logic             stream_begin,
    input  logic             stream_done,
    input  logic             halt_in,
    output logic             out,
    output logic             out_valid,
    output logic             halt_stream,
    output logic             stuff_done,
    output logic [CNT_W-1:0] stuff_count
);

    // The run counter never has to hold STUFF_LEN itself: reaching
    // STUFF_LEN-1 with another 1 on the input diverts straight to STUFF.
    localparam int               ONES_W = $clog2(STUFF_LEN);
    localparam logic [ONES_W-1:0] C_LAST = ONES_W'(STUFF_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STUFF  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ONES_W-1:0]  r_ones_cnt;
    logic [ONES_W-1:0]  w_ones_nxt;
    logic               r_done_pend;
    logic               w_done_pend_nxt;
    logic               r_stuff_done;
    logic               w_stuff_done_nxt;
    logic [CNT_W-1:0]   r_stuff_count;
    logic [CNT_W-1:0]   w_stuff_count_nxt;

    logic               w_idle;
    logic               w_stuff;
    logic               w_data_bit;
    logic [ONES_W-1:0]  w_run;

    assign w_idle     = (r_state == S_IDLE);
    assign w_stuff    = (r_state == S_STUFF);
    // A packet bit is being passed through this cycle (before halt_in).
    assign w_data_bit = (w_idle & stream_begin) | (r_state == S_ACTIVE);
    // A new packet always starts a fresh run, whatever the previous packet
    // left behind in the counter.
    assign w_run      = w_idle ? '0 : r_ones_cnt;

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign out         = w_stuff ? 1'b0 : (w_data_bit & in);
    assign out_valid   = ~halt_in & (w_data_bit | w_stuff);
    assign halt_stream = halt_in | w_stuff;
    assign stuff_done  = r_stuff_done;
    assign stuff_count = r_stuff_count;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_ones_nxt        = r_ones_cnt;
        w_done_pend_nxt   = r_done_pend;
        w_stuff_done_nxt  = 1'b0;
        w_stuff_count_nxt = r_stuff_count;

        // halt_in freezes everything; the done pulse still drops to 0.
        if (!halt_in) begin
            if (w_data_bit) begin
                if (w_idle) begin
                    w_stuff_count_nxt = '0;
                end

                if (in && (w_run == C_LAST)) begin
                    // This 1 completes a run; the stuffed 0 goes out next
                    // cycle, so a coincident stream_done is deferred.
                    w_state_nxt     = S_STUFF;
                    w_ones_nxt      = '0;
                    w_done_pend_nxt = stream_done;
                end else begin
                    w_ones_nxt = in ? (w_run + ONES_W'(1)) : '0;
                    if (stream_done) begin
                        w_state_nxt      = S_IDLE;
                        w_stuff_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ACTIVE;
                    end
                end
            end else if (w_stuff) begin
                if (r_stuff_count != {CNT_W{1'b1}}) begin
                    w_stuff_count_nxt = r_stuff_count + CNT_W'(1);
                end

                if (r_done_pend) begin
                    w_state_nxt      = S_IDLE;
                    w_stuff_done_nxt = 1'b1;
                    w_done_pend_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_ACTIVE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state       <= S_IDLE;
            r_ones_cnt    <= '0;
            r_done_pend   <= 1'b0;
            r_stuff_done  <= 1'b0;
            r_stuff_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ones_cnt    <= w_ones_nxt;
            r_done_pend   <= w_done_pend_nxt;
            r_stuff_done  <= w_stuff_done_nxt;
            r_stuff_count <= w_stuff_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_bit_stuffer
// Description : Self-checking bench for usb_bit_stuffer. Packets are expanded
//               into the expected stuffed bit stream by a reference model and
//               the DUT output is compared bit by bit, including halt_stream,
//               the done pulse and the stuffed-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_bit_stuffer;

    localparam int STUFF_LEN = 6;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst_L;
    logic             in;
    logic             stream_begin;
    logic             stream_done;
    logic             halt_in;
    logic             out;
    logic             out_valid;
    logic             halt_stream;
    logic             stuff_done;
    logic [CNT_W-1:0] stuff_count;

    int total = 0;
    int bad   = 0;

    bit pkt[$];

    usb_bit_stuffer #(
        .STUFF_LEN (STUFF_LEN),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .in           (in),
        .stream_begin (stream_begin),
        .stream_done  (stream_done),
        .halt_in      (halt_in),
        .out          (out),
        .out_valid    (out_valid),
        .halt_stream  (halt_stream),
        .stuff_done   (stuff_done),
        .stuff_count  (stuff_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Send the packet held in pkt[] with random halt_in at hp percent,
    // acting as the upstream stage that only advances when not held.
    task automatic run_packet(input int hp);
        bit exp_bit[$];
        bit exp_stf[$];
        int run   = 0;
        int nstf  = 0;
        int len   = pkt.size();
        int idx   = 0;
        int ei    = 0;
        int n;
        int exp_cnt;
        bit h;
        bit fin = 0;

        // Reference: emit every bit; after STUFF_LEN 1s in a row add a 0.
        foreach (pkt[k]) begin
            exp_bit.push_back(pkt[k]);
            exp_stf.push_back(1'b0);
            run = pkt[k] ? run + 1 : 0;
            if (run == STUFF_LEN) begin
                exp_bit.push_back(1'b0);
                exp_stf.push_back(1'b1);
                run = 0;
                nstf++;
            end
        end
        n       = exp_bit.size();
        exp_cnt = (nstf > 255) ? 255 : nstf;

        for (int cyc = 0; cyc < 4 * n + 100; cyc++) begin
            @(negedge clk);
            h = (hp > 0) && ($urandom_range(0, 99) < hp);
            halt_in = h;
            if (idx < len) begin
                in           = pkt[idx];
                stream_begin = (idx == 0);
                stream_done  = (idx == len - 1);
            end else begin
                in           = 1'b0;
                stream_begin = 1'b0;
                stream_done  = 1'b0;
            end
            #1;
            if (ei < n) begin
                check("out_valid", out_valid, !h);
                if (!h) check("out", out, exp_bit[ei]);
                check("halt_stream", halt_stream, h | exp_stf[ei]);
                check("stuff_done_early", stuff_done, 1'b0);
                if (!h) begin
                    if (!exp_stf[ei]) idx++;
                    ei++;
                end
            end else begin
                check("stuff_done", stuff_done, 1'b1);
                check("stuff_count", stuff_count, exp_cnt);
                check("idle_valid", out_valid, 1'b0);
                check("idle_halt", halt_stream, h);
                fin = 1;
                break;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d of %0d bits expected all", ei, n);
        end
        halt_in      = 1'b0;
        stream_begin = 1'b0;
        stream_done  = 1'b0;
        in           = 1'b0;
    endtask

    task automatic load_bits(input int nbits, input logic [31:0] pattern);
        pkt.delete();
        for (int i = 0; i < nbits; i++) pkt.push_back(pattern[i]);
    endtask

    task automatic load_ones(input int nbits);
        pkt.delete();
        for (int i = 0; i < nbits; i++) pkt.push_back(1'b1);
    endtask

    initial begin
        rst_L        = 1'b0;
        in           = 1'b0;
        stream_begin = 1'b0;
        stream_done  = 1'b0;
        halt_in      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out", out, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_halt", halt_stream, 1'b0);
        check("rst_done", stuff_done, 1'b0);
        check("rst_count", stuff_count, 0);
        @(negedge clk);
        rst_L = 1'b1;

        // Plain packet, no stuffing.
        load_bits(8, 32'hA5);
        run_packet(0);
        // 13 ones: two stuffed zeros.
        load_ones(13);
        run_packet(0);
        // Exactly STUFF_LEN ones ending the packet.
        load_ones(6);
        run_packet(0);
        // Ones with heavy halt activity.
        load_ones(7);
        run_packet(40);
        // Single-bit packets.
        load_bits(1, 32'h1);
        run_packet(0);
        load_bits(1, 32'h0);
        run_packet(20);

        // Reset in the middle of a run of ones abandons the packet.
        @(negedge clk);
        in = 1'b1; stream_begin = 1'b1;
        @(negedge clk);
        stream_begin = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_halt", halt_stream, 1'b0);
        check("midrst_count", stuff_count, 0);
        @(negedge clk);
        rst_L = 1'b1;
        in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_nodone", stuff_done, 1'b0);
        end
        load_ones(3);
        run_packet(0);

        // Long run of ones: counter must saturate.
        load_ones(2100);
        run_packet(0);
        // Next packet clears the saturated count.
        load_bits(4, 32'h3);
        run_packet(0);

        // Random packets biased toward 1s to exercise stuffing.
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 40);
            int op  = $urandom_range(50, 95);
            int hp  = $urandom_range(0, 30);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 99) < op);
            run_packet(hp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_bit_stuffer.md
Name: usb_bit_stuffer

Overview:
- Serial transmit stage that sits directly downstream of the CRC generator and upstream of the NRZI encoder.
- Passes the packet bit stream through unchanged, except that it inserts a 0 after every STUFF_LEN consecutive 1s (USB bit-stuffing rule).
- While inserting, it back-pressures the upstream CRC stage through halt_stream.
- Signals end of the stuffed packet and keeps a per-packet count of inserted bits.

Parameters:
- STUFF_LEN, 6, number of consecutive 1s that triggers insertion of one 0 (legal range 2..7).
- CNT_W, 8, width of the stuffed-bit counter (saturating).

Ports:
- clk  input  1  clock.
- rst_L  input  1  reset, asynchronous, active-low.
- in  input  1  serial data bit from the upstream (CRC) stage.
- stream_begin  input  1  the current in bit is the first bit of a packet (sampled in IDLE only).
- stream_done  input  1  the current in bit is the last bit of the packet.
- halt_in  input  1  downstream hold; freezes all state and is forwarded upstream.
- out  output  1  serial bit to NRZI encoder.
- out_valid  output  1  out carries a packet bit this cycle.
- halt_stream  output  1  upstream hold (upstream must not advance its bit).
- stuff_done  output  1  one-cycle registered pulse after the final bit of a packet has left.
- stuff_count  output  CNT_W  number of 0s inserted in the current/last packet.

Behaviour:
- Reset (async, rst_L low):
  - state=IDLE, ones_cnt=0, done_pend=0, stuff_done=0, stuff_count=0.
  - Combinational outputs then evaluate to out=0, out_valid=0, halt_stream=0.
  - Reset mid-packet abandons the packet; no stuff_done is issued.
- States: IDLE, ACTIVE, STUFF.
- Combinational outputs:
  - out = 0 in STUFF; = in when data is being passed (IDLE with stream_begin, or ACTIVE); = 0 otherwise.
  - out_valid = ~halt_in & ((IDLE & stream_begin) | ACTIVE | STUFF).
  - halt_stream = halt_in | (state==STUFF).
- halt_in=1: no register changes, stuff_done held at 0, out_valid=0. Takes priority over every other event.
- Data bit (IDLE & stream_begin, or ACTIVE, with halt_in=0):
  - If in=1 and ones_cnt==STUFF_LEN-1: next state=STUFF, ones_cnt<=0, done_pend<=stream_done.
  - Else if in=1: ones_cnt<=ones_cnt+1.
  - Else (in=0): ones_cnt<=0.
  - If not entering STUFF and stream_done=1: next state=IDLE, stuff_done<=1.
  - Otherwise next state=ACTIVE.
- Entry from IDLE on stream_begin:
  - stuff_count clears to 0 in the same clock edge.
  - ones_cnt starts from 0; no carry-over between packets.
- STUFF (halt_in=0):
  - Emits one 0 bit; in is ignored (upstream is held).
  - stuff_count <= stuff_count+1, saturating at all-ones.
  - If done_pend=1: next state=IDLE, stuff_done<=1, done_pend<=0. Otherwise next state=ACTIVE.
- A stuffed 0 resets the run. The bit after a stuffed 0 starts a new run at 1 if it is a 1.
- Latency: zero cycles pass-through for data bits. Each stuffed bit adds exactly one cycle.
- stuff_done is a single-cycle pulse. It deasserts on the next non-halted edge; if halt_in is asserted on that edge, it is held at 0.
- stream_begin in ACTIVE/STUFF: ignored.
- stream_done in IDLE without stream_begin: ignored.
- stream_begin and stream_done together in IDLE: single-bit packet, handled per the data-bit rules above.
- Packet ending in a run of exactly STUFF_LEN 1s: the trailing stuffed 0 is still sent before stuff_done.

Test Plan:
- Reset, then packet 8'b1010_0101 (LSB first) with stream_done on the 8th bit -> out equals in, out_valid high for 8 cycles, halt_stream never high, stuff_done pulses 1 cycle after the 8th bit, stuff_count=0.
- Packet of 13 consecutive 1s -> zeros inserted after the 6th and 12th 1s. out_valid high for 15 cycles; halt_stream high in cycles 7 and 14 (1-based); upstream bit held during those cycles; stuff_count=2.
- Packet 6'b111111 with stream_done on the 6th bit -> 7th cycle out=0, out_valid=1, halt_stream=1. stuff_done pulses on the following cycle; stuff_count=1.
- 5 ones, halt_in=1 for 3 cycles, then 2 more ones -> no output and no state change while halted (out_valid=0, halt_stream=1). The 0 is inserted after the 6th one, not the 5th; the 7th one follows the stuffed 0.
- rst_L pulsed low after 4 ones of a 1-run packet, then a new packet of 3 ones + stream_done -> no stuffing, stuff_count=0, exactly one stuff_done (for the second packet only).
- 300 packets of 7 ones each (STUFF_LEN=6) accumulated in one packet, i.e. 2100 ones -> stuff_count saturates at 255, does not wrap.
